// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the step control unit and its helpers.
//   state_e : FSM state encodings (also driven out on Stage)
//   ysel_e  : write-back source codes driven on Y_Select
//   WAIT_CNT_W : width of the MFC wait counter
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    YSEL_ALU  = 2'd0,
    YSEL_MEM  = 2'd1,
    YSEL_RET  = 2'd2
  } ysel_e;

  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/mfc_wait_timer.sv
// Counts cycles spent waiting for memory function complete.
//   clk_i     : rising-edge clock
//   rst_i     : asynchronous active-high reset
//   clr_i     : clear the count (takes priority over counting)
//   cnt_en_i  : count one waited cycle
//   limit_i   : count value at which the wait is considered expired
//   expired_o : registered count has reached limit_i
module mfc_wait_timer
  import cpu_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  cnt_en_i,
  input  logic [WAIT_CNT_W-1:0] limit_i,
  output logic                  expired_o
);

  logic [WAIT_CNT_W-1:0] count_q, count_d;

  // Saturating so a stuck enable can never wrap back below the limit.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (cnt_en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == limit_i);

endmodule

// File: rtl/step_control_unit.sv
// Multi-cycle CPU step controller: FETCH -> DECODE -> EXECUTE -> MEMORY ->
// WRITEBACK, with MFC handshaking, a memory wait timeout and a sticky HALT.
//   Clock, Reset              : clock, asynchronous active-high reset
//   InstructionFormat..MFC    : decoded instruction attributes and memory ack
//   IR_Enable..RF_WRITE       : datapath controls, decoded from state + inputs
//   Stage                     : registered state encoding
//   Fault, Timeout            : sticky halt / timeout-caused-halt flags
//   InstrCount                : retired-instruction counter (wraps)
module step_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter bit         WAIT_MFC     = 1'b1,
  parameter int         MEM_TIMEOUT  = 15,
  parameter bit         HALT_ON_IFNR = 1'b1,
  parameter logic [1:0] IMM_FMT      = 2'b01,
  parameter int         CNT_W        = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       InstructionFormat,
  input  logic             NOP_FLAG,
  input  logic             IFNR_FLAG,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             BranchTaken,
  input  logic             WriteBack,
  input  logic             MFC,
  output logic             IR_Enable,
  output logic             PC_Enable,
  output logic             PC_Select,
  output logic             INC_Select,
  output logic             RA_Enable,
  output logic             RB_Enable,
  output logic             B_Select,
  output logic             RZ_Enable,
  output logic             CCR_Enable,
  output logic             RM_Enable,
  output logic             MA_Select,
  output logic             MEM_Read,
  output logic             MEM_Write,
  output logic [1:0]       Y_Select,
  output logic             RY_Enable,
  output logic             RF_WRITE,
  output logic [2:0]       Stage,
  output logic             Fault,
  output logic             Timeout,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [WAIT_CNT_W-1:0] TMO_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic             fault_q, timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire, fault_set, tmo_set, wait_en, expired, mem_done;

  assign mem_done = MFC || !WAIT_MFC;

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    fault_set  = 1'b0;
    tmo_set    = 1'b0;
    wait_en    = 1'b0;
    IR_Enable  = 1'b0;
    PC_Enable  = 1'b0;
    PC_Select  = 1'b0;
    INC_Select = 1'b0;
    RA_Enable  = 1'b0;
    RB_Enable  = 1'b0;
    B_Select   = 1'b0;
    RZ_Enable  = 1'b0;
    CCR_Enable = 1'b0;
    RM_Enable  = 1'b0;
    MA_Select  = 1'b0;
    MEM_Read   = 1'b0;
    MEM_Write  = 1'b0;
    Y_Select   = YSEL_ALU;
    RY_Enable  = 1'b0;
    RF_WRITE   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        MA_Select = 1'b1;
        MEM_Read  = 1'b1;
        if (mem_done) begin
          IR_Enable = 1'b1;
          PC_Enable = 1'b1;
          PC_Select = 1'b1;
          state_d   = ST_DECODE;
        end else if (expired) begin
          state_d   = ST_HALT;
          fault_set = 1'b1;
          tmo_set   = 1'b1;
        end else begin
          wait_en = 1'b1;
        end
      end
      ST_DECODE: begin
        RA_Enable = 1'b1;
        RB_Enable = 1'b1;
        if ((IFNR_FLAG && HALT_ON_IFNR) || (MemRead && MemWrite)) begin
          state_d   = ST_HALT;
          fault_set = 1'b1;
        end else if (NOP_FLAG || IFNR_FLAG) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        RZ_Enable  = 1'b1;
        CCR_Enable = 1'b1;
        RM_Enable  = 1'b1;
        B_Select   = (InstructionFormat == IMM_FMT);
        if (BranchTaken) begin
          PC_Enable  = 1'b1;
          PC_Select  = 1'b1;
          INC_Select = 1'b1;
        end
        state_d = ST_MEMORY;
      end
      ST_MEMORY: begin
        if (MemRead || MemWrite) begin
          MEM_Read  = MemRead;
          MEM_Write = MemWrite;
          if (mem_done) begin
            RY_Enable = 1'b1;
            Y_Select  = MemRead ? YSEL_MEM : YSEL_ALU;
            state_d   = ST_WRITEBACK;
          end else if (expired) begin
            state_d   = ST_HALT;
            fault_set = 1'b1;
            tmo_set   = 1'b1;
          end else begin
            wait_en = 1'b1;
          end
        end else begin
          RY_Enable = 1'b1;
          state_d   = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        RF_WRITE = WriteBack;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // Unused encodings are treated as a fault rather than silently resumed.
        state_d   = ST_HALT;
        fault_set = 1'b1;
      end
    endcase
  end

  // The timeout only fires when the registered count already equals the
  // limit and MFC is still low, so an MFC arriving in that cycle wins.
  mfc_wait_timer u_wait (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .clr_i     (state_d != state_q),
    .cnt_en_i  (wait_en),
    .limit_i   (TMO_LIMIT),
    .expired_o (expired)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_FETCH;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (fault_set) fault_q <= 1'b1;
      if (tmo_set) timeout_q <= 1'b1;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Stage      = state_q;
  assign Fault      = fault_q;
  assign Timeout    = timeout_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_step_control_unit.sv
// Bench for step_control_unit: two instances share one stimulus stream.
//   A: MEM_TIMEOUT=4, HALT_ON_IFNR=0, CNT_W=4 (short timeout, fast wrap)
//   B: default parameters
// Each cycle both are compared against a behavioural reference model.
module tb_step_control_unit;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] InstructionFormat = 2'b00;
  logic NOP_FLAG = 0, IFNR_FLAG = 0, MemRead = 0, MemWrite = 0;
  logic BranchTaken = 0, WriteBack = 0, MFC = 0;

  logic IR_Enable_a, PC_Enable_a, PC_Select_a, INC_Select_a, RA_Enable_a, RB_Enable_a;
  logic B_Select_a, RZ_Enable_a, CCR_Enable_a, RM_Enable_a, MA_Select_a, MEM_Read_a;
  logic MEM_Write_a, RY_Enable_a, RF_WRITE_a, Fault_a, Timeout_a;
  logic [1:0] Y_Select_a;
  logic [2:0] Stage_a;
  logic [3:0] InstrCount_a;

  logic IR_Enable_b, PC_Enable_b, PC_Select_b, INC_Select_b, RA_Enable_b, RB_Enable_b;
  logic B_Select_b, RZ_Enable_b, CCR_Enable_b, RM_Enable_b, MA_Select_b, MEM_Read_b;
  logic MEM_Write_b, RY_Enable_b, RF_WRITE_b, Fault_b, Timeout_b;
  logic [1:0] Y_Select_b;
  logic [2:0] Stage_b;
  logic [15:0] InstrCount_b;

  always #5 Clock = ~Clock;

  step_control_unit #(.WAIT_MFC(1'b1), .MEM_TIMEOUT(4), .HALT_ON_IFNR(1'b0),
                      .IMM_FMT(2'b01), .CNT_W(4)) u_dut_a (
    .Clock(Clock), .Reset(Reset), .InstructionFormat(InstructionFormat),
    .NOP_FLAG(NOP_FLAG), .IFNR_FLAG(IFNR_FLAG), .MemRead(MemRead), .MemWrite(MemWrite),
    .BranchTaken(BranchTaken), .WriteBack(WriteBack), .MFC(MFC),
    .IR_Enable(IR_Enable_a), .PC_Enable(PC_Enable_a), .PC_Select(PC_Select_a),
    .INC_Select(INC_Select_a), .RA_Enable(RA_Enable_a), .RB_Enable(RB_Enable_a),
    .B_Select(B_Select_a), .RZ_Enable(RZ_Enable_a), .CCR_Enable(CCR_Enable_a),
    .RM_Enable(RM_Enable_a), .MA_Select(MA_Select_a), .MEM_Read(MEM_Read_a),
    .MEM_Write(MEM_Write_a), .Y_Select(Y_Select_a), .RY_Enable(RY_Enable_a),
    .RF_WRITE(RF_WRITE_a), .Stage(Stage_a), .Fault(Fault_a), .Timeout(Timeout_a),
    .InstrCount(InstrCount_a));

  step_control_unit u_dut_b (
    .Clock(Clock), .Reset(Reset), .InstructionFormat(InstructionFormat),
    .NOP_FLAG(NOP_FLAG), .IFNR_FLAG(IFNR_FLAG), .MemRead(MemRead), .MemWrite(MemWrite),
    .BranchTaken(BranchTaken), .WriteBack(WriteBack), .MFC(MFC),
    .IR_Enable(IR_Enable_b), .PC_Enable(PC_Enable_b), .PC_Select(PC_Select_b),
    .INC_Select(INC_Select_b), .RA_Enable(RA_Enable_b), .RB_Enable(RB_Enable_b),
    .B_Select(B_Select_b), .RZ_Enable(RZ_Enable_b), .CCR_Enable(CCR_Enable_b),
    .RM_Enable(RM_Enable_b), .MA_Select(MA_Select_b), .MEM_Read(MEM_Read_b),
    .MEM_Write(MEM_Write_b), .Y_Select(Y_Select_b), .RY_Enable(RY_Enable_b),
    .RF_WRITE(RF_WRITE_b), .Stage(Stage_b), .Fault(Fault_b), .Timeout(Timeout_b),
    .InstrCount(InstrCount_b));

  // Control word bit positions: IR PCE PCS INC RA RB BS RZ CCR RM MA MRD MWR Y[1:0] RY RF
  localparam int B_IR = 16, B_PCE = 15, B_PCS = 14, B_INC = 13, B_RA = 12, B_RB = 11;
  localparam int B_BS = 10, B_RZ = 9, B_CCR = 8, B_RM = 7, B_MA = 6, B_MRD = 5, B_MWR = 4;
  localparam int B_RY = 1, B_RF = 0;

  logic [16:0] ctrl_a, ctrl_b;
  assign ctrl_a = {IR_Enable_a, PC_Enable_a, PC_Select_a, INC_Select_a, RA_Enable_a,
                   RB_Enable_a, B_Select_a, RZ_Enable_a, CCR_Enable_a, RM_Enable_a,
                   MA_Select_a, MEM_Read_a, MEM_Write_a, Y_Select_a, RY_Enable_a, RF_WRITE_a};
  assign ctrl_b = {IR_Enable_b, PC_Enable_b, PC_Select_b, INC_Select_b, RA_Enable_b,
                   RB_Enable_b, B_Select_b, RZ_Enable_b, CCR_Enable_b, RM_Enable_b,
                   MA_Select_b, MEM_Read_b, MEM_Write_b, Y_Select_b, RY_Enable_b, RF_WRITE_b};

  typedef struct {
    bit         wait_mfc;
    int         tmo;
    bit         halt_ifnr;
    logic [1:0] imm;
    int         cnt_mod;
  } cfg_t;

  // Model state: step number (0 fetch .. 4 write-back, 7 halted), cycles waited
  // in the current step, sticky flags and retired count.
  typedef struct {
    int stg;
    int waits;
    bit flt;
    bit tmo;
    int cnt;
  } mst_t;

  cfg_t cfg_a, cfg_b;
  mst_t ma, mb;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected control word for the current inputs, plus the model state after the edge.
  function automatic logic [16:0] ref_step(input cfg_t c, input mst_t s, output mst_t n);
    logic [16:0] w;
    bit done, acc, gave_up;
    w = '0;
    n = s;
    done = MFC || !c.wait_mfc;
    acc = MemRead || MemWrite;
    gave_up = !done && (s.waits >= c.tmo);
    if (s.stg == 0) begin
      w[B_MA] = 1'b1;
      w[B_MRD] = 1'b1;
      if (done) begin
        w[B_IR] = 1'b1; w[B_PCE] = 1'b1; w[B_PCS] = 1'b1;
        n.stg = 1;
      end
    end else if (s.stg == 1) begin
      w[B_RA] = 1'b1;
      w[B_RB] = 1'b1;
      if ((IFNR_FLAG && c.halt_ifnr) || (MemRead && MemWrite)) begin
        n.stg = 7; n.flt = 1;
      end else if (NOP_FLAG || IFNR_FLAG) begin
        n.stg = 0; n.cnt = (s.cnt + 1) % c.cnt_mod;
      end else begin
        n.stg = 2;
      end
    end else if (s.stg == 2) begin
      w[B_RZ] = 1'b1; w[B_CCR] = 1'b1; w[B_RM] = 1'b1;
      w[B_BS] = (InstructionFormat == c.imm);
      if (BranchTaken) begin
        w[B_PCE] = 1'b1; w[B_PCS] = 1'b1; w[B_INC] = 1'b1;
      end
      n.stg = 3;
    end else if (s.stg == 3) begin
      if (!acc) begin
        w[B_RY] = 1'b1;
        n.stg = 4;
      end else begin
        w[B_MRD] = MemRead;
        w[B_MWR] = MemWrite;
        if (done) begin
          w[B_RY] = 1'b1;
          w[3:2] = MemRead ? 2'd1 : 2'd0;
          n.stg = 4;
        end
      end
    end else if (s.stg == 4) begin
      w[B_RF] = WriteBack;
      n.stg = 0;
      n.cnt = (s.cnt + 1) % c.cnt_mod;
    end
    // Waiting only happens in fetch or in a memory access.
    if ((s.stg == 0 || (s.stg == 3 && acc)) && !done) begin
      if (gave_up) begin
        n.stg = 7; n.flt = 1; n.tmo = 1;
      end else begin
        n.waits = s.waits + 1;
      end
    end
    if (n.stg != s.stg) n.waits = 0;
    return w;
  endfunction

  // One clock cycle: called just after a falling edge with inputs already set.
  task automatic tick();
    mst_t na, nb;
    logic [16:0] ea, eb;
    #1;
    if (Reset) begin
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};
    end
    ea = ref_step(cfg_a, ma, na);
    eb = ref_step(cfg_b, mb, nb);
    check("ctrl_a", 32'(ctrl_a), 32'(ea));
    check("stat_a", {27'd0, Stage_a, Fault_a, Timeout_a}, {27'd0, 3'(ma.stg), ma.flt, ma.tmo});
    check("cnt_a", 32'(InstrCount_a), ma.cnt);
    check("ctrl_b", 32'(ctrl_b), 32'(eb));
    check("stat_b", {27'd0, Stage_b, Fault_b, Timeout_b}, {27'd0, 3'(mb.stg), mb.flt, mb.tmo});
    check("cnt_b", 32'(InstrCount_b), mb.cnt);
    @(posedge Clock);
    if (!Reset) begin
      ma = na;
      mb = nb;
    end
    @(negedge Clock);
  endtask

  task automatic clear_inputs();
    InstructionFormat = 2'b00;
    NOP_FLAG = 0; IFNR_FLAG = 0; MemRead = 0; MemWrite = 0;
    BranchTaken = 0; WriteBack = 0; MFC = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  int seq27[6] = '{0, 1, 2, 3, 4, 0};
  int seq29[3] = '{0, 1, 0};

  initial begin
    cfg_a = '{1'b1, 4, 1'b0, 2'b01, 16};
    cfg_b = '{1'b1, 15, 1'b1, 2'b01, 65536};
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};
    @(negedge Clock);

    // Reset state
    do_reset();
    #1;
    check("rst_stage", 32'(Stage_b), 0);
    check("rst_flags", {30'd0, Fault_b, Timeout_b}, 0);
    check("rst_cnt", 32'(InstrCount_b), 0);

    // ALU instruction with MFC held high
    clear_inputs();
    MFC = 1; WriteBack = 1; InstructionFormat = 2'b01;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("alu_stage", 32'(Stage_b), seq27[i]);
      check("alu_rfw", 32'(RF_WRITE_b), (i == 4) ? 1 : 0);
      if (i < 5) tick();
    end
    check("alu_cnt", 32'(InstrCount_b), 1);

    // NOP
    NOP_FLAG = 1; WriteBack = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nop_stage", 32'(Stage_b), seq29[i]);
      check("nop_quiet", {29'd0, RZ_Enable_b, RY_Enable_b, RF_WRITE_b}, 0);
      if (i < 2) tick();
    end
    check("nop_cnt", 32'(InstrCount_b), 2);
    NOP_FLAG = 0;

    // Load with three MFC-low memory cycles
    MemRead = 1; MFC = 1;
    tick(); tick(); tick();
    MFC = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld_wait", {28'd0, Stage_b, MEM_Read_b, MA_Select_b, RY_Enable_b},
            {28'd0, 3'd3, 1'b1, 1'b0, 1'b0});
      tick();
    end
    MFC = 1;
    #1;
    check("ld_done", {27'd0, Stage_b, Y_Select_b, RY_Enable_b, MEM_Read_b},
          {27'd0, 3'd3, 2'd1, 1'b1, 1'b1});
    tick(); tick();
    MemRead = 0;
    check("ld_cnt", 32'(InstrCount_b), 3);

    // Unrecognised format: retired on A, halts B
    IFNR_FLAG = 1;
    tick(); tick();
    #1;
    check("ifnr_a", {28'd0, Stage_a, Fault_a}, {28'd0, 3'd0, 1'b0});
    check("ifnr_b", {27'd0, Stage_b, Fault_b, Timeout_b}, {27'd0, 3'd7, 1'b1, 1'b0});
    check("ifnr_acnt", 32'(InstrCount_a), 4);
    IFNR_FLAG = 0;

    // Fetch timeout on A (limit 4)
    do_reset();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("tmo_wait", 32'(Stage_a), 0);
      tick();
    end
    #1;
    check("tmo_halt", {27'd0, Stage_a, Fault_a, Timeout_a}, {27'd0, 3'd7, 1'b1, 1'b1});
    MFC = 1; BranchTaken = 1; MemRead = 1; WriteBack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("halt_quiet", 32'(ctrl_a), 0);
      tick();
    end

    // Reset pulsed in the middle of a fetch wait
    do_reset();
    clear_inputs();
    tick(); tick();
    #2 Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check("rel_fetch", {29'd0, Stage_a, MEM_Read_a}, {29'd0, 3'd0, 1'b1});
    check("rel_cnt", {12'd0, InstrCount_b, InstrCount_a}, 0);
    // A cleared wait counter must again tolerate the full wait before halting.
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rel_nohalt", 32'(Stage_a), 0);
      tick();
    end

    // Counter wrap on A (4-bit) via 16 NOPs
    do_reset();
    clear_inputs();
    NOP_FLAG = 1; MFC = 1;
    for (int i = 0; i < 32; i++) tick();
    #1;
    check("wrap_a", 32'(InstrCount_a), 0);
    check("wrap_b", 32'(InstrCount_b), 16);

    // Randomised traffic
    clear_inputs();
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 90) == 0);
      InstructionFormat = 2'($urandom_range(0, 3));
      NOP_FLAG = ($urandom_range(0, 7) == 0);
      IFNR_FLAG = ($urandom_range(0, 19) == 0);
      MemRead = ($urandom_range(0, 2) == 0);
      MemWrite = ($urandom_range(0, 3) == 0);
      BranchTaken = $urandom_range(0, 1);
      WriteBack = $urandom_range(0, 1);
      MFC = ((i / 64) % 3 == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      tick();
    end
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
